// File: rtl/uart_echo_fifo.sv
// UART echo buffer: received bytes queue in a FIFO and are relaunched to the transmitter one frame at a time.
// Optional CR->CRLF expansion is compiled in with `define UART_ECHO_CRLF_EN.
module uart_echo_fifo #(
  parameter int data_bits_p  = 8,
  parameter int els_p        = 16,
  parameter int drop_width_p = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         rx_v_i,
  input  logic [data_bits_p-1:0]       rx_i,
  output logic                         tx_v_o,
  output logic [data_bits_p-1:0]       tx_o,
  input  logic                         tx_done_i,
  output logic [$clog2(els_p+1)-1:0]   count_o,
  output logic                         overflow_o,
  output logic [drop_width_p-1:0]      drop_count_o
);

  // state   | meaning
  // IDLE    | nothing in flight, waiting for a buffered byte
  // SEND    | one-cycle launch of the FIFO head, head popped
  // WAIT    | transmitter busy, waiting for tx_done_i
  // SEND_LF | one-cycle launch of LF after a CR (CRLF build only)
  // WAIT_LF | transmitter busy with the LF (CRLF build only)

  localparam int aw = $clog2(els_p);
  localparam int cw = $clog2(els_p + 1);
  localparam logic [cw-1:0] full_c = cw'(els_p);

`ifdef UART_ECHO_CRLF_EN
  localparam logic [data_bits_p-1:0] cr_c = data_bits_p'(13);
  localparam logic [data_bits_p-1:0] lf_c = data_bits_p'(10);

  if (data_bits_p < 7) begin : g_bad_width
    $error("uart_echo_fifo: CRLF expansion needs data_bits_p >= 7");
  end

  typedef enum logic [2:0] {IDLE, SEND, WAIT, SEND_LF, WAIT_LF} state_e;
`else
  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_e;
`endif

  state_e                  state_q, state_d;
  logic [aw-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [cw-1:0]           count_q, count_d;
  logic [data_bits_p-1:0]  tx_q, tx_d;
  logic                    overflow_q, overflow_d;
  logic [drop_width_p-1:0] drop_q, drop_d;
  logic [data_bits_p-1:0]  mem_q [els_p];
  logic                    push, pop, drop;

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    tx_v_o  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: if (count_q != '0) state_d = SEND;
      SEND: begin
        tx_v_o  = 1'b1;
        pop     = 1'b1;
        tx_d    = mem_q[rd_ptr_q];
        state_d = WAIT;
      end
      WAIT: if (tx_done_i) begin
`ifdef UART_ECHO_CRLF_EN
        state_d = (tx_q == cr_c) ? SEND_LF : IDLE;
`else
        state_d = IDLE;
`endif
      end
`ifdef UART_ECHO_CRLF_EN
      SEND_LF: begin
        tx_v_o  = 1'b1;
        tx_d    = lf_c;
        state_d = WAIT_LF;
      end
      WAIT_LF: if (tx_done_i) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // tx_d already carries the byte being launched, so tx_o is valid in the launch cycle and held after it
  assign tx_o = tx_d;

  always_comb begin
    push       = rx_v_i && ((count_q != full_c) || pop);
    drop       = rx_v_i && !push;
    wr_ptr_d   = push ? wr_ptr_q + aw'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + aw'(1) : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop)      count_d = count_q + cw'(1);
    else if (pop && !push) count_d = count_q - cw'(1);
    overflow_d = overflow_q | drop;
    drop_d     = (drop && (drop_q != '1)) ? drop_q + drop_width_p'(1) : drop_q;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_q       <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= rx_i;
  end

  assign count_o      = count_q;
  assign overflow_o   = overflow_q;
  assign drop_count_o = drop_q;

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Self-checking bench for uart_echo_fifo with a transmitter model and a queue-based reference.
// Define UART_ECHO_CRLF_EN for both files to exercise the CRLF build.
module tb_uart_echo_fifo;
  localparam int DB  = 8;
  localparam int ELS = 16;
  localparam int DW  = 8;
  localparam int CW  = $clog2(ELS + 1);

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b0;
  logic          rx_v_i = 1'b0;
  logic [DB-1:0] rx_i = '0;
  logic          tx_done_i = 1'b0;
  logic          tx_v_o;
  logic [DB-1:0] tx_o;
  logic [CW-1:0] count_o;
  logic          overflow_o;
  logic [DW-1:0] drop_count_o;

  uart_echo_fifo #(.data_bits_p(DB), .els_p(ELS), .drop_width_p(DW)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .rx_v_i(rx_v_i), .rx_i(rx_i),
    .tx_v_o(tx_v_o), .tx_o(tx_o), .tx_done_i(tx_done_i),
    .count_o(count_o), .overflow_o(overflow_o), .drop_count_o(drop_count_o));

  always #5 clk_i = ~clk_i;

  int passed = 0;
  int total  = 0;
  logic [DB-1:0] got_q[$];
  logic [DB-1:0] exp_q[$];
  bit auto_tx = 0, done_once = 0, busy = 0, chk_en = 0;
  int gap = 3, cd = 0, n_rx = 0, n_tx = 0;

  // transmitter model and occupancy reference: occupancy = bytes received minus bytes launched
  always @(negedge clk_i) begin
    tx_done_i = 1'b0;
    if (reset_i) busy = 0;
    else if (tx_v_o) begin
      got_q.push_back(tx_o);
      busy = 1;
      cd = gap;
    end else if (busy && (done_once || (auto_tx && cd == 0))) begin
      tx_done_i = 1'b1;
      busy = 0;
      done_once = 0;
    end else if (busy && cd > 0) cd--;
    if (chk_en) begin
      total++;
      if (count_o !== CW'(n_rx - n_tx))
        $display("FAIL rand_count: got %0d expected %0d", count_o, n_rx - n_tx);
      else passed++;
      if (rx_v_i) n_rx++;
      if (tx_v_o) n_tx++;
    end
  end

  task automatic cyc();
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset();
    cyc();
    reset_i = 1'b1; rx_v_i = 1'b0; auto_tx = 0; done_once = 0; gap = 3;
    cyc();
    reset_i = 1'b0;
    got_q.delete();
  endtask

  task automatic send_byte(input logic [DB-1:0] b);
    rx_v_i = 1'b1; rx_i = b;
    cyc();
    rx_v_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int quiet = 0;
    int k = 0;
    while (quiet < 6 && k < 3000) begin
      cyc(); k++;
      if (count_o == '0 && !tx_v_o && !busy) quiet++; else quiet = 0;
    end
    total++;
    if (quiet < 6) $display("FAIL %s_drain: got timeout expected idle", name);
    else passed++;
  endtask

  task automatic compare_seq(input string name);
    total++;
    if (got_q.size() !== exp_q.size())
      $display("FAIL %s_len: got %0d expected %0d", name, got_q.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i])
        $display("FAIL %s_byte%0d: got %02h expected %02h", name, i, got_q[i], exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_reset();
    #2 reset_i = 1'b1;
    #1;
    total += 5;
    if (count_o !== '0)      $display("FAIL rst_count: got %0d expected 0", count_o); else passed++;
    if (overflow_o !== 1'b0) $display("FAIL rst_ovf: got %b expected 0", overflow_o); else passed++;
    if (drop_count_o !== '0) $display("FAIL rst_drop: got %0d expected 0", drop_count_o); else passed++;
    if (tx_v_o !== 1'b0)     $display("FAIL rst_txv: got %b expected 0", tx_v_o); else passed++;
    if (tx_o !== '0)         $display("FAIL rst_txo: got %02h expected 00", tx_o); else passed++;
    cyc();
    reset_i = 1'b0; rx_v_i = 1'b1; rx_i = 8'h5A;
    cyc();
    rx_v_i = 1'b0;
    total++;
    if (count_o !== CW'(1)) $display("FAIL first_edge_count: got %0d expected 1", count_o); else passed++;
    cyc();
    total++;
    if (tx_v_o !== 1'b1 || tx_o !== 8'h5A)
      $display("FAIL first_edge_tx: got v=%b %02h expected v=1 5a", tx_v_o, tx_o);
    else passed++;
  endtask

  task automatic test_single();
    do_reset();
    repeat (10) cyc();
    send_byte(8'h41);
    total += 2;
    if (count_o !== CW'(1)) $display("FAIL single_c11: got %0d expected 1", count_o); else passed++;
    if (tx_v_o !== 1'b0) $display("FAIL single_v11: got %b expected 0", tx_v_o); else passed++;
    cyc();
    total += 2;
    if (tx_v_o !== 1'b1) $display("FAIL single_v12: got %b expected 1", tx_v_o); else passed++;
    if (tx_o !== 8'h41) $display("FAIL single_o12: got %02h expected 41", tx_o); else passed++;
    cyc();
    total += 3;
    if (count_o !== '0) $display("FAIL single_c13: got %0d expected 0", count_o); else passed++;
    if (tx_v_o !== 1'b0) $display("FAIL single_v13: got %b expected 0", tx_v_o); else passed++;
    if (tx_o !== 8'h41) $display("FAIL single_hold: got %02h expected 41", tx_o); else passed++;
    auto_tx = 1;
    wait_drain("single");
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 20; i++) send_byte(DB'(i));
    total += 4;
    if (count_o !== CW'(16)) $display("FAIL ovf_count: got %0d expected 16", count_o); else passed++;
    if (overflow_o !== 1'b1) $display("FAIL ovf_flag: got %b expected 1", overflow_o); else passed++;
    if (drop_count_o !== DW'(3)) $display("FAIL ovf_drops: got %0d expected 3", drop_count_o); else passed++;
    if (got_q.size() !== 1) $display("FAIL ovf_launched: got %0d expected 1", got_q.size()); else passed++;
    auto_tx = 1;
    wait_drain("ovf");
    exp_q.delete();
    for (int i = 0; i < 17; i++) exp_q.push_back(DB'(i));
    compare_seq("ovf_order");
  endtask

  task automatic test_full_pop();
    int k = 0;
    do_reset();
    for (int i = 0; i < 17; i++) send_byte(DB'(8'h20 + i));
    total++;
    if (count_o !== CW'(16)) $display("FAIL fullpop_fill: got %0d expected 16", count_o); else passed++;
    done_once = 1;
    while (!tx_v_o && k < 20) begin cyc(); k++; end
    total++;
    if (!tx_v_o) $display("FAIL fullpop_send: got timeout expected tx_v_o"); else passed++;
    send_byte(8'hA5);
    total += 2;
    if (count_o !== CW'(16)) $display("FAIL fullpop_count: got %0d expected 16", count_o); else passed++;
    if (drop_count_o !== '0) $display("FAIL fullpop_drop: got %0d expected 0", drop_count_o); else passed++;
    auto_tx = 1;
    wait_drain("fullpop");
    exp_q.delete();
    for (int i = 0; i < 17; i++) exp_q.push_back(DB'(8'h20 + i));
    exp_q.push_back(8'hA5);
    compare_seq("fullpop_order");
  endtask

  task automatic test_reset_mid_wait();
    int n;
    do_reset();
    for (int i = 0; i < 6; i++) send_byte(DB'(8'h60 + i));
    cyc();
    total++;
    if (count_o !== CW'(5)) $display("FAIL midrst_pre: got %0d expected 5", count_o); else passed++;
    #1 reset_i = 1'b1;
    #1;
    total += 3;
    if (count_o !== '0) $display("FAIL midrst_count: got %0d expected 0", count_o); else passed++;
    if (overflow_o !== 1'b0) $display("FAIL midrst_ovf: got %b expected 0", overflow_o); else passed++;
    if (tx_v_o !== 1'b0) $display("FAIL midrst_txv: got %b expected 0", tx_v_o); else passed++;
    cyc();
    reset_i = 1'b0;
    n = got_q.size();
    auto_tx = 1;
    repeat (30) cyc();
    total++;
    if (got_q.size() !== n) $display("FAIL midrst_quiet: got %0d launches expected 0", got_q.size() - n); else passed++;
  endtask

  task automatic test_drop_sat();
    do_reset();
    for (int i = 0; i < 17 + 254; i++) send_byte(DB'(i));
    total++;
    if (drop_count_o !== 8'hFE) $display("FAIL sat_254: got %02h expected fe", drop_count_o); else passed++;
    repeat (2) send_byte(8'h77);
    total++;
    if (drop_count_o !== 8'hFF) $display("FAIL sat_256: got %02h expected ff", drop_count_o); else passed++;
    repeat (3) send_byte(8'h78);
    total += 2;
    if (drop_count_o !== 8'hFF) $display("FAIL sat_hold: got %02h expected ff", drop_count_o); else passed++;
    if (overflow_o !== 1'b1) $display("FAIL sat_ovf: got %b expected 1", overflow_o); else passed++;
    auto_tx = 1;
    wait_drain("sat");
  endtask

  task automatic test_crlf();
    do_reset();
    auto_tx = 1; gap = 2;
    send_byte(8'h0D);
    send_byte(8'h42);
    wait_drain("crlf");
    exp_q.delete();
    exp_q.push_back(8'h0D);
`ifdef UART_ECHO_CRLF_EN
    exp_q.push_back(8'h0A);
`endif
    exp_q.push_back(8'h42);
    compare_seq("crlf");
  endtask

  task automatic test_random();
    logic [DB-1:0] b;
    do_reset();
    auto_tx = 1;
    n_rx = 0; n_tx = 0;
    chk_en = 1;
    exp_q.delete();
    for (int burst = 0; burst < 5; burst++) begin
      gap = $urandom_range(0, 5);
      for (int j = $urandom_range(1, 16); j > 0; j--) begin
        b = DB'($urandom);
        if (b == 8'h0D) b = 8'h0E;
        exp_q.push_back(b);
        send_byte(b);
        repeat ($urandom_range(0, 2)) cyc();
      end
      wait_drain("rand");
    end
    chk_en = 0;
    compare_seq("rand_order");
    total++;
    if (drop_count_o !== '0) $display("FAIL rand_drop: got %0d expected 0", drop_count_o); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_full_pop();
    test_reset_mid_wait();
    test_drop_sat();
    test_crlf();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
